gpc_column_accumulator: RTL
===========================

GPC_COLUMN_ACCUMULATOR -- requirements
Module: gpc_column_accumulator

Interface
REQ-001 SHALL have parameter NUM_SAMPLES, default 16: number of counter results summed per output word (>= 2).
REQ-002 SHALL have parameter ACC_W, default 8: accumulator and output sum width (>= 4).
REQ-003 SHALL define derived width CNT_W = clog2(NUM_SAMPLES+1).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  in_o carries a (2,2,3) counter result.
REQ-007 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-008 SHALL have port in_o  input  4  4-bit (2,2,3) counter output O, unsigned value 0..15.
REQ-009 SHALL have port in_flush  input  1  close the current result early.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port out_sum  output  ACC_W  sum of accepted samples, modulo 2^ACC_W.
REQ-013 SHALL have port out_count  output  CNT_W  number of samples in out_sum.
REQ-014 SHALL have port out_ovf  output  1  at least one addition carried out of ACC_W bits.

Function
REQ-015 SHALL accept a sample only on an edge where in_valid && in_ready.
REQ-016 SHALL register each accepted sample in a stage-1 register at the accepting edge E, then add it into the accumulator at edge E+1 (two-stage pipeline).
REQ-017 SHALL implement states ACCUM, DRAIN, HOLD; in_ready = (state==ACCUM), registered, no combinational path from in_valid.
REQ-018 In ACCUM, on acceptance of sample number NUM_SAMPLES, SHALL go to DRAIN at that edge.
REQ-019 In ACCUM, in_flush high with count>0, or with a sample accepted that edge, SHALL go to DRAIN; a sample accepted on the flush edge SHALL be included.
REQ-020 In ACCUM, in_flush with count==0 and no acceptance SHALL be ignored.
REQ-021 In DRAIN and HOLD, in_valid and in_flush SHALL be ignored.
REQ-022 DRAIN SHALL last exactly one cycle, then go to HOLD; out_valid = (state==HOLD).
REQ-023 Therefore out_valid SHALL first be high two cycles after the edge accepting the final sample.
REQ-024 In HOLD, out_sum, out_count, out_ovf SHALL stay stable until out_valid && out_ready.
REQ-025 On out_valid && out_ready, SHALL clear accumulator, count and ovf, and go to ACCUM; in_ready high from the next cycle.
REQ-026 Additions SHALL zero-extend in_o to ACC_W and wrap modulo 2^ACC_W; any carry-out SHALL set ovf, sticky until result handshake.
REQ-027 out_count SHALL increment once per accepted sample and never exceed NUM_SAMPLES.
REQ-028 Idle cycles (in_valid low) in ACCUM SHALL not change accumulator or count.

Reset
REQ-029 On rst high, SHALL asynchronously enter ACCUM, clear stage-1 register, accumulator, count, ovf.
REQ-030 During and after reset, in_ready=0 while rst high, then 1; out_valid=0; out_sum=0; out_count=0; out_ovf=0.
REQ-031 Reset mid-operation (any state) SHALL discard the partial or pending result with no output handshake.

Verification
REQ-032 NUM_SAMPLES=4, ACC_W=8: in_o 15,15,15,15 back-to-back -> in_ready low after 4th accept, out_valid two cycles later, out_sum=60, out_count=4, out_ovf=0.
REQ-033 out_ready held low 5 cycles in HOLD -> outputs stable; in_valid pulses ignored; after handshake next result excludes them.
REQ-034 Samples 3,5 then in_flush alone -> out_sum=8, out_count=2; flush asserted with sample 7 accepted -> out_sum=15, out_count=3.
REQ-035 ACC_W=5, NUM_SAMPLES=4, samples 15x4 -> out_sum=28, out_ovf=1; following result 1,1,1,1 -> out_sum=4, out_ovf=0.
REQ-036 Sparse in_valid (1-of-3 cycles) with values 0,9,2,4 -> out_sum=15, out_count=4; in_flush with count 0 -> no result.
REQ-037 rst asserted in DRAIN and in HOLD -> out_valid drops immediately, all outputs 0, next result counts only post-reset samples.

Source files
------------

// File: rtl/gpc_column_accumulator.sv
// Sums NUM_SAMPLES (2,2,3) counter results through a two-stage pipeline and
// presents the sum, sample count and sticky carry flag under a valid/ready handshake.
module gpc_column_accumulator #(
  parameter int NUM_SAMPLES = 16,
  parameter int ACC_W       = 8,
  localparam int CNT_W      = $clog2(NUM_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_o,
  input  logic             in_flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

  state_t             state;
  state_t             next_state;
  logic               s1_valid;
  logic [3:0]         s1_data;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   count;
  logic               ovf;
  logic               accept;
  logic               release_res;
  logic [CNT_W-1:0]   cnt_inc;
  logic [ACC_W:0]     sum_ext;

  assign accept      = in_valid & in_ready;
  assign release_res = out_valid & out_ready;
  assign cnt_inc     = count + CNT_W'(1);
  assign sum_ext     = {1'b0, acc} + (ACC_W + 1)'(s1_data);

  // Next-state logic; a sample accepted on the flush edge still joins this result.
  always_comb begin
    next_state = state;
    case (state)
      ACCUM: begin
        if (accept && (cnt_inc == CNT_W'(NUM_SAMPLES))) begin
          next_state = DRAIN;
        end else if (in_flush && ((count != CNT_W'(0)) || accept)) begin
          next_state = DRAIN;
        end else begin
          next_state = ACCUM;
        end
      end
      DRAIN: next_state = HOLD;
      HOLD: begin
        if (release_res) begin
          next_state = ACCUM;
        end else begin
          next_state = HOLD;
        end
      end
      default: next_state = ACCUM;
    endcase
  end

  // State register with registered handshake flags decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= next_state;
      in_ready  <= (next_state == ACCUM);
      out_valid <= (next_state == HOLD);
    end
  end

  // Stage 1: capture the accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= 4'd0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= in_o;
      end
    end
  end

  // Stage 2: accumulate with wrap-around; the carry flag is sticky until the result is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (release_res) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (s1_valid) begin
        acc <= sum_ext[ACC_W-1:0];
        ovf <= ovf | sum_ext[ACC_W];
      end
      if (accept) begin
        count <= cnt_inc;
      end
    end
  end

  assign out_sum   = acc;
  assign out_count = count;
  assign out_ovf   = ovf;

endmodule
